alu_share_arbiter: RTL and testbench

//  Shares the single 32-bit combinational ALU (module Alu) between two requesters, e.g. the main

---
 rtl/alu_share_arbiter_pkg.sv | 19 +
 rtl/alu_share_arbiter_if.sv | 41 ++++
 rtl/alu_share_arbiter_alu.sv | 40 ++++
 rtl/alu_share_arbiter.sv | 111 +++++++++++
 tb/tb_alu_share_arbiter.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared op codes and FSM encoding for the two-port ALU arbiter.
package alu_share_arbiter_pkg;

  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluXor = 3'b011;
  localparam logic [2:0] AluNor = 3'b100;
  localparam logic [2:0] AluSrl = 3'b101;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the two requesters and the shared ALU arbiter.
interface alu_share_arbiter_if #(
  parameter int unsigned DataW = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [DataW-1:0] req0_a;
  logic [DataW-1:0] req0_b;
  logic [2:0]       req0_oper;
  logic             req1_valid;
  logic             req1_ready;
  logic [DataW-1:0] req1_a;
  logic [DataW-1:0] req1_b;
  logic [2:0]       req1_oper;
  logic             rsp0_valid;
  logic             rsp0_ready;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [DataW-1:0] rsp_result;
  logic             rsp_zero;
  logic             rsp_overflow;
  logic             busy;
  logic             ovf_sticky;
  logic             ovf_clr;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_oper,
    input  req1_valid, req1_a, req1_b, req1_oper,
    input  rsp0_ready, rsp1_ready, ovf_clr,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    output rsp_result, rsp_zero, rsp_overflow, busy, ovf_sticky
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_oper,
    output req1_valid, req1_a, req1_b, req1_oper,
    output rsp0_ready, rsp1_ready, ovf_clr,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    input  rsp_result, rsp_zero, rsp_overflow, busy, ovf_sticky
  );
endinterface

// File: rtl/alu_share_arbiter_alu.sv
// Combinational 32-bit ALU; overflow is only meaningful for add and sub.
module alu_share_arbiter_alu
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned DataW = 32
) (
  input  logic [DataW-1:0] a,
  input  logic [DataW-1:0] b,
  input  logic [2:0]       oper,
  output logic [DataW-1:0] result,
  output logic             zero,
  output logic             overflow
);

  // Decode the op; signed overflow from operand/result sign bits.
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (oper)
      AluAnd: result = a & b;
      AluOr:  result = a | b;
      AluXor: result = a ^ b;
      AluNor: result = ~(a | b);
      AluAdd: begin
        result   = a + b;
        overflow = (a[DataW-1] == b[DataW-1]) && (result[DataW-1] != a[DataW-1]);
      end
      AluSub: begin
        result   = a - b;
        overflow = (a[DataW-1] != b[DataW-1]) && (result[DataW-1] != a[DataW-1]);
      end
      AluSlt: result = {{(DataW-1){1'b0}}, (a < b)};
      AluSrl: result = b >> 1;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two valid/ready requesters: IDLE -> EXEC -> RESP -> IDLE.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned RrEn  = 1,
  parameter int unsigned DataW = 32
) (
  input logic                clk_in,
  input logic                rst_n_in,
  alu_share_arbiter_if.slave bus
);

  state_e           state_q, state_d;
  logic             last_grant_q, port_q, grant;
  logic [1:0]       req_v;
  logic             accept, rsp_ack;
  logic [DataW-1:0] a_q, b_q, result_q, alu_result;
  logic [2:0]       oper_q;
  logic             alu_zero, alu_ovf, zero_q, ovf_q, sticky_q;

  assign req_v = {bus.req1_valid, bus.req0_valid};

  // Pick one requester; ties alternate in round-robin mode, otherwise port 0 wins.
  always_comb begin
    grant = 1'b0;
    if (req_v == 2'b11) begin
      grant = (RrEn != 0) ? ~last_grant_q : 1'b0;
    end else begin
      grant = req_v[1];
    end
  end

  assign accept  = (state_q == StIdle) && req_v[grant];
  assign rsp_ack = (state_q == StResp) && (port_q ? bus.rsp1_ready : bus.rsp0_ready);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (rsp_ack) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= StIdle;
    else           state_q <= state_d;
  end

  // Capture the granted request; last_grant resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      a_q          <= '0;
      b_q          <= '0;
      oper_q       <= '0;
      port_q       <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (accept) begin
      a_q          <= grant ? bus.req1_a : bus.req0_a;
      b_q          <= grant ? bus.req1_b : bus.req0_b;
      oper_q       <= grant ? bus.req1_oper : bus.req0_oper;
      port_q       <= grant;
      last_grant_q <= grant;
    end
  end

  // Register ALU outputs in EXEC; they hold until the next EXEC.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (state_q == StExec) begin
      result_q <= alu_result;
      zero_q   <= alu_zero;
      ovf_q    <= alu_ovf;
    end
  end

  // Sticky overflow; a set in the same cycle as a clear takes priority.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)                            sticky_q <= 1'b0;
    else if ((state_q == StExec) && alu_ovf) sticky_q <= 1'b1;
    else if (bus.ovf_clr)                     sticky_q <= 1'b0;
  end

  alu_share_arbiter_alu #(
    .DataW (DataW)
  ) u_alu (
    .a        (a_q),
    .b        (b_q),
    .oper     (oper_q),
    .result   (alu_result),
    .zero     (alu_zero),
    .overflow (alu_ovf)
  );

  assign bus.req0_ready   = (state_q == StIdle) && req_v[0] && (grant == 1'b0);
  assign bus.req1_ready   = (state_q == StIdle) && req_v[1] && (grant == 1'b1);
  assign bus.rsp0_valid   = (state_q == StResp) && (port_q == 1'b0);
  assign bus.rsp1_valid   = (state_q == StResp) && (port_q == 1'b1);
  assign bus.rsp_result   = result_q;
  assign bus.rsp_zero     = zero_q;
  assign bus.rsp_overflow = ovf_q;
  assign bus.busy         = (state_q != StIdle);
  assign bus.ovf_sticky   = sticky_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench: a round-robin and a fixed-priority instance share one stimulus set,
// selected by sel; a negedge monitor checks every response against a reference model.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;
  logic hold_rsp = 1'b0;
  logic ovf_clr = 1'b0;

  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]  req0_oper = '0, req1_oper = '0;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;

  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_overflow, busy, ovf_sticky;

  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int   acc_q0[$];
  int   acc_q1[$];
  int   grant_log[$];
  logic prev_v0 = 1'b0, prev_v1 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_share_arbiter_if #(.DataW(32)) rr_if ();
  alu_share_arbiter_if #(.DataW(32)) fp_if ();

  assign rr_if.req0_valid = req0_valid & ~sel;
  assign rr_if.req1_valid = req1_valid & ~sel;
  assign rr_if.rsp0_ready = rsp0_ready & ~sel;
  assign rr_if.rsp1_ready = rsp1_ready & ~sel;
  assign fp_if.req0_valid = req0_valid & sel;
  assign fp_if.req1_valid = req1_valid & sel;
  assign fp_if.rsp0_ready = rsp0_ready & sel;
  assign fp_if.rsp1_ready = rsp1_ready & sel;
  assign rr_if.req0_a = req0_a;
  assign rr_if.req0_b = req0_b;
  assign rr_if.req0_oper = req0_oper;
  assign rr_if.req1_a = req1_a;
  assign rr_if.req1_b = req1_b;
  assign rr_if.req1_oper = req1_oper;
  assign rr_if.ovf_clr = ovf_clr;
  assign fp_if.req0_a = req0_a;
  assign fp_if.req0_b = req0_b;
  assign fp_if.req0_oper = req0_oper;
  assign fp_if.req1_a = req1_a;
  assign fp_if.req1_b = req1_b;
  assign fp_if.req1_oper = req1_oper;
  assign fp_if.ovf_clr = ovf_clr;

  assign req0_ready   = sel ? fp_if.req0_ready : rr_if.req0_ready;
  assign req1_ready   = sel ? fp_if.req1_ready : rr_if.req1_ready;
  assign rsp0_valid   = sel ? fp_if.rsp0_valid : rr_if.rsp0_valid;
  assign rsp1_valid   = sel ? fp_if.rsp1_valid : rr_if.rsp1_valid;
  assign rsp_result   = sel ? fp_if.rsp_result : rr_if.rsp_result;
  assign rsp_zero     = sel ? fp_if.rsp_zero : rr_if.rsp_zero;
  assign rsp_overflow = sel ? fp_if.rsp_overflow : rr_if.rsp_overflow;
  assign busy         = sel ? fp_if.busy : rr_if.busy;
  assign ovf_sticky   = sel ? fp_if.ovf_sticky : rr_if.ovf_sticky;

  alu_share_arbiter #(.RrEn(1), .DataW(32)) dut_rr (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (rr_if.slave)
  );

  alu_share_arbiter #(.RrEn(0), .DataW(32)) dut_fp (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (fp_if.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference ALU from the op definitions, using wide signed arithmetic for overflow.
  function automatic exp_t ref_alu(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    exp_t   e;
    longint full;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.ovf = 1'b0;
    case (op)
      3'b000: e.result = a & b;
      3'b001: e.result = a | b;
      3'b011: e.result = a ^ b;
      3'b100: e.result = ~(a | b);
      3'b010: begin
        full = sa + sb;
        e.result = 32'(full);
        e.ovf = (full > 64'sd2147483647) || (full < -64'sd2147483648);
      end
      3'b110: begin
        full = sa - sb;
        e.result = 32'(full);
        e.ovf = (full > 64'sd2147483647) || (full < -64'sd2147483648);
      end
      3'b111: e.result = (a < b) ? 32'd1 : 32'd0;
      default: e.result = b / 2;
    endcase
    e.zero = (e.result == 32'd0);
    return e;
  endfunction

  task automatic drive(input int p, input logic v, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    if (p == 0) begin
      req0_valid = v; req0_oper = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_oper = op; req1_a = a; req1_b = b;
    end
  endtask

  // Issue one request and wait for acceptance; keep valid high afterwards unless last.
  task automatic send(input int p, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input bit last);
    bit ok;
    ok = 1'b0;
    if (p == 0) exp_q0.push_back(ref_alu(op, a, b));
    else        exp_q1.push_back(ref_alu(op, a, b));
    drive(p, 1'b1, op, a, b);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((p == 0) ? req0_ready : req1_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk($sformatf("accept_timeout_p%0d", p), 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (last || !ok) drive(p, 1'b0, op, a, b);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q0.size() + exp_q1.size()) != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_grants(input string name, input int e0, input int e1, input int e2,
                            input int e3);
    int e[4];
    e = '{e0, e1, e2, e3};
    chk({name, "_count"}, 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      chk($sformatf("%s_%0d", name, i), 32'(grant_log[i]), 32'(e[i]));
  endtask

  // Response-ready generator: mostly ready, sometimes stalls, forced low when holding.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      rsp0_ready = hold_rsp ? 1'b0 : ($urandom_range(0, 3) != 0);
      rsp1_ready = hold_rsp ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: log grants, check latency, pop and compare responses on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (req0_valid && req0_ready) begin
        acc_q0.push_back(cyc); grant_log.push_back(0);
        chk("ready_exclusive_p0", {31'd0, req1_ready}, 32'd0);
      end
      if (req1_valid && req1_ready) begin
        acc_q1.push_back(cyc); grant_log.push_back(1);
        chk("ready_exclusive_p1", {31'd0, req0_ready}, 32'd0);
      end
      if (rsp0_valid && !prev_v0) begin
        if (acc_q0.size() == 0) chk("rsp0_unexpected", 32'd1, 32'd0);
        else chk("latency_p0", 32'(cyc - acc_q0.pop_front()), 32'd2);
      end
      if (rsp1_valid && !prev_v1) begin
        if (acc_q1.size() == 0) chk("rsp1_unexpected", 32'd1, 32'd0);
        else chk("latency_p1", 32'(cyc - acc_q1.pop_front()), 32'd2);
      end
      if (rsp0_valid && rsp0_ready) begin
        chk("rsp_other_p0", {31'd0, rsp1_valid}, 32'd0);
        if (exp_q0.size() == 0) chk("rsp0_no_expect", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = exp_q0.pop_front();
          chk("result_p0", rsp_result, e.result);
          chk("zero_p0", {31'd0, rsp_zero}, {31'd0, e.zero});
          chk("ovf_p0", {31'd0, rsp_overflow}, {31'd0, e.ovf});
          if (e.ovf) chk("sticky_p0", {31'd0, ovf_sticky}, 32'd1);
        end
      end
      if (rsp1_valid && rsp1_ready) begin
        chk("rsp_other_p1", {31'd0, rsp0_valid}, 32'd0);
        if (exp_q1.size() == 0) chk("rsp1_no_expect", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = exp_q1.pop_front();
          chk("result_p1", rsp_result, e.result);
          chk("zero_p1", {31'd0, rsp_zero}, {31'd0, e.zero});
          chk("ovf_p1", {31'd0, rsp_overflow}, {31'd0, e.ovf});
          if (e.ovf) chk("sticky_p1", {31'd0, ovf_sticky}, 32'd1);
        end
      end
    end
    prev_v0 <= rsp0_valid;
    prev_v1 <= rsp1_valid;
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_rsp0_valid"}, {31'd0, rsp0_valid}, 32'd0);
    chk({tag, "_rsp1_valid"}, {31'd0, rsp1_valid}, 32'd0);
    chk({tag, "_result"}, rsp_result, 32'd0);
    chk({tag, "_zero"}, {31'd0, rsp_zero}, 32'd0);
    chk({tag, "_ovf"}, {31'd0, rsp_overflow}, 32'd0);
    chk({tag, "_sticky"}, {31'd0, ovf_sticky}, 32'd0);
  endtask

  task automatic rand_port(input int p, input int n);
    logic [31:0] a, b;
    for (int i = 0; i < n; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      if ($urandom_range(0, 7) == 0) b = a;
      send(p, 3'($urandom_range(0, 7)), a, b, 1'b1);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    logic [31:0] held;
    bit          seen;
    // Reset values on both instances.
    repeat (3) @(posedge clk);
    #1;
    sel = 1'b0; #1; chk_reset_outputs("reset_rr");
    sel = 1'b1; #1; chk_reset_outputs("reset_fp");
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Port 0 add overflow, then port 1 sub to zero.
    send(0, AluAdd, 32'h7FFF_FFFF, 32'd1, 1'b1);
    drain();
    send(1, AluSub, 32'h1234, 32'h1234, 1'b1);
    drain();

    // Round robin with both ports continuously valid.
    grant_log.delete();
    fork
      begin
        send(0, AluAnd, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0);
        send(0, AluAnd, 32'hAAAA_5555, 32'hFFFF_0000, 1'b1);
      end
      begin
        send(1, AluOr, 32'h0000_1111, 32'h2222_0000, 1'b0);
        send(1, AluOr, 32'h8000_0000, 32'h0000_0001, 1'b1);
      end
    join
    drain();
    chk_grants("rr_grant", 0, 1, 0, 1);

    // Fixed priority: port 0 keeps winning until it drops valid.
    sel = 1'b1;
    grant_log.delete();
    fork
      begin
        send(0, AluXor, 32'h1, 32'h3, 1'b0);
        send(0, AluSlt, 32'h1, 32'hFFFF_FFFF, 1'b0);
        send(0, AluSrl, 32'h0, 32'h8000_0001, 1'b1);
      end
      send(1, AluNor, 32'h0, 32'h0, 1'b1);
    join
    drain();
    chk_grants("fp_grant", 0, 0, 0, 1);
    sel = 1'b0;
    #1;

    // Response back-pressure: output held while port 1 waits.
    hold_rsp = 1'b1;
    send(0, AluXor, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
    fork
      send(1, AluAdd, 32'd5, 32'd7, 1'b1);
    join_none
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = rsp0_valid;
    end
    chk("hold_rsp0_seen", {31'd0, seen}, 32'd1);
    held = rsp_result;
    chk("hold_first_result", held, 32'hDEAD_BEEF ^ 32'h1234_5678);
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, rsp0_valid}, 32'd1);
      chk("hold_result", rsp_result, held);
      chk("hold_busy", {31'd0, busy}, 32'd1);
      chk("hold_ready0", {31'd0, req0_ready}, 32'd0);
      chk("hold_ready1", {31'd0, req1_ready}, 32'd0);
    end
    hold_rsp = 1'b0;
    wait fork;
    drain();

    // Randomized traffic on both instances.
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      fork
        rand_port(0, 15);
        rand_port(1, 15);
      join
      drain();
    end
    sel = 1'b0;
    #1;

    // Reset during EXEC discards the op.
    hold_rsp = 1'b1;
    drive(0, 1'b1, AluAdd, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = req0_ready;
    end
    chk("rst_accept_seen", {31'd0, seen}, 32'd1);
    @(posedge clk);
    #1;
    drive(0, 1'b0, AluAdd, 32'd0, 32'd0);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    acc_q0.delete();
    acc_q1.delete();
    grant_log.delete();
    hold_rsp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    fork
      send(0, AluAnd, 32'hFF, 32'h0F, 1'b1);
      send(1, AluOr, 32'hF0, 32'h0F, 1'b1);
    join
    drain();
    chk("post_rst_first_grant", 32'(grant_log.size() > 0 ? grant_log[0] : 9), 32'd0);

    // Clear coinciding with an overflow set: set wins; a later lone clear clears.
    send(0, AluSub, 32'h8000_0000, 32'd1, 1'b1);
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    chk("clr_vs_set_sticky", {31'd0, ovf_sticky}, 32'd1);
    drain();
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    chk("clr_sticky", {31'd0, ovf_sticky}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
